// File: rtl/regwb_scheduler.sv
// regwb_scheduler: arbitrates register-bank writeback requesters, settles the mux selects, then strobes reg_wr.
// Optional macro ROUND_ROBIN_EN selects round-robin arbitration; otherwise the lowest index wins.
module regwb_scheduler #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_dst,
    input  logic [4*NREQ-1:0] req_src,
    input  logic [4:0]        wr_reg,
    output logic [2:0]        regdst_sel,
    output logic [3:0]        memtoreg_sel,
    output logic              reg_wr,
    output logic [NREQ-1:0]   req_ack,
    output logic              req_err,
    output logic              busy
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, ACK} state_t;

    state_t         state;
    logic [IDW-1:0] id;
    logic [2:0]     cnt;
    logic [IDW-1:0] win_id;
    logic [2:0]     win_dst;
    logic [3:0]     win_src;
    logic [NREQ-1:0] win_hot;
`ifdef ROUND_ROBIN_EN
    logic [IDW-1:0] ptr;
    int unsigned    best;
    int unsigned    dist;
`endif

    always_comb begin
        win_id = '0;
`ifdef ROUND_ROBIN_EN
        // Distance from ptr+1 going upward with wrap; the nearest requester wins.
        best = NREQ;
        dist = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            dist = (i + NREQ - 32'(ptr) - 1) % NREQ;
            if (req[i] && (dist < best)) begin
                best   = dist;
                win_id = IDW'(i);
            end
        end
`else
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (req[i-1]) win_id = IDW'(i - 1);
        end
`endif
        win_dst = '0;
        win_src = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_id) begin
                win_dst = req_dst[3*i +: 3];
                win_src = req_src[4*i +: 4];
            end
        end
        win_hot = NREQ'(1) << win_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            id           <= '0;
            cnt          <= '0;
            regdst_sel   <= '0;
            memtoreg_sel <= '0;
            reg_wr       <= 1'b0;
            req_ack      <= '0;
            req_err      <= 1'b0;
            busy         <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr          <= IDW'(NREQ - 1);
`endif
        end else begin
            reg_wr  <= 1'b0;
            req_ack <= '0;
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        id   <= win_id;
                        busy <= 1'b1;
`ifdef ROUND_ROBIN_EN
                        ptr  <= win_id;
`endif
                        // Illegal destination: drop straight to ACK, selects keep their old value.
                        if (win_dst > 3'd4) begin
                            req_ack <= win_hot;
                            req_err <= 1'b1;
                            state   <= ACK;
                        end else begin
                            regdst_sel   <= win_dst;
                            memtoreg_sel <= win_src;
                            cnt          <= 3'(SETTLE_CYCLES - 1);
                            state        <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        reg_wr <= (wr_reg != 5'd0);
                        state  <= WRITE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WRITE: begin
                    req_ack <= NREQ'(1) << id;
                    state   <= ACK;
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regwb_scheduler.sv
// Self-checking bench for regwb_scheduler against a transaction-level model of arbitration and timing.
// Honours ROUND_ROBIN_EN the same way as the design.
module tb_regwb_scheduler;
    localparam int NREQ   = 4;
    localparam int SETTLE = 3;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_dst;
    logic [4*NREQ-1:0] req_src;
    logic [4:0]        wr_reg;
    logic [2:0]        regdst_sel;
    logic [3:0]        memtoreg_sel;
    logic              reg_wr;
    logic [NREQ-1:0]   req_ack;
    logic              req_err;
    logic              busy;

    int vectors;
    int miscompares;

    // Model state: arbitration pointer and the selects the mux should currently show.
    int         m_ptr;
    logic [2:0] m_dst;
    logic [3:0] m_src;

    regwb_scheduler #(.NREQ(NREQ), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dst(req_dst), .req_src(req_src),
        .wr_reg(wr_reg), .regdst_sel(regdst_sel), .memtoreg_sel(memtoreg_sel),
        .reg_wr(reg_wr), .req_ack(req_ack), .req_err(req_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_slot(input int i, input logic [2:0] d, input logic [3:0] s);
        req_dst[3*i +: 3] = d;
        req_src[4*i +: 4] = s;
    endtask

    function automatic logic [13:0] obs();
        return {busy, regdst_sel, memtoreg_sel, reg_wr, req_ack, req_err};
    endfunction

    function automatic logic [13:0] pack(input logic b, input logic [2:0] d, input logic [3:0] s,
                                         input logic w, input logic [NREQ-1:0] a, input logic e);
        return {b, d, s, w, a, e};
    endfunction

    function automatic int model_winner(input logic [NREQ-1:0] r);
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (r[idx]) return idx;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = NREQ - 1;
        m_dst = 3'd0;
        m_src = 4'd0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = '1;
        req_dst = {NREQ{3'd1}};
        req_src = {NREQ{4'd3}};
        wr_reg  = 5'd7;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (obs() !== 14'h0) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d got %h expected %h", c, obs(), 14'h0);
            end
        end
        reset = 1'b0;
        req   = '0;
        model_reset();
        tick();
        vectors++;
        if (obs() !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_idle got %h expected %h", obs(), 14'h0);
        end
    endtask

    task automatic test_single_write();
        set_slot(1, 3'd1, 4'd2);
        wr_reg = 5'd8;
        req    = 4'b0010;
        tick();
        vectors++;
        if ({regdst_sel, memtoreg_sel, busy, reg_wr} !== {3'd1, 4'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_sel got %h/%h busy=%b wr=%b expected 1/2 busy=1 wr=0",
                     regdst_sel, memtoreg_sel, busy, reg_wr);
        end
        repeat (SETTLE - 1) begin
            tick();
            vectors++;
            if (reg_wr !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single_settle got wr=%b busy=%b expected wr=0 busy=1", reg_wr, busy);
            end
        end
        tick();
        vectors++;
        if (reg_wr !== 1'b1 || req_ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_write got wr=%b ack=%b expected wr=1 ack=0000", reg_wr, req_ack);
        end
        tick();
        vectors++;
        if (obs() !== pack(1'b1, 3'd1, 4'd2, 1'b0, 4'b0010, 1'b0)) begin
            miscompares++;
            $display("FAIL single_ack got %h expected %h", obs(), pack(1'b1, 3'd1, 4'd2, 1'b0, 4'b0010, 1'b0));
        end
        req = '0;
        tick();
        vectors++;
        if (obs() !== pack(1'b0, 3'd1, 4'd2, 1'b0, 4'b0000, 1'b0)) begin
            miscompares++;
            $display("FAIL single_idle got %h expected %h", obs(), pack(1'b0, 3'd1, 4'd2, 1'b0, 4'b0000, 1'b0));
        end
        m_ptr = 1;
        m_dst = 3'd1;
        m_src = 4'd2;
    endtask

    task automatic test_arbitration();
        int t;
        int w;
        logic [NREQ-1:0] exp_ack;
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) set_slot(i, 3'd2, 4'(i + 4));
        wr_reg = 5'd5;
        req    = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            w = model_winner(req);
            exp_ack = '0;
            exp_ack[w] = 1'b1;
            t = 0;
            while (t < 10) begin
                tick();
                t++;
                if (req_ack !== '0) break;
            end
            vectors++;
            if (t != SETTLE + 2) begin
                miscompares++;
                $display("FAIL arb_latency txn%0d got %0d cycles expected %0d", n, t, SETTLE + 2);
            end
            vectors++;
            if (req_ack !== exp_ack || memtoreg_sel !== 4'(w + 4)) begin
                miscompares++;
                $display("FAIL arb_order txn%0d got ack=%b src=%h expected ack=%b src=%h",
                         n, req_ack, memtoreg_sel, exp_ack, 4'(w + 4));
            end
            m_ptr = w;
            m_dst = 3'd2;
            m_src = 4'(w + 4);
            req[w] = 1'b0;
            tick();
            req = (n == 3) ? 4'b0000 : 4'b0101;
        end
    endtask

    task automatic test_illegal_dst();
        set_slot(3, 3'd5, 4'd9);
        wr_reg = 5'd12;
        req    = 4'b1000;
        tick();
        vectors++;
        if (obs() !== pack(1'b1, m_dst, m_src, 1'b0, 4'b1000, 1'b1)) begin
            miscompares++;
            $display("FAIL illegal_ack got %h expected %h", obs(), pack(1'b1, m_dst, m_src, 1'b0, 4'b1000, 1'b1));
        end
        req = '0;
        tick();
        vectors++;
        if (obs() !== pack(1'b0, m_dst, m_src, 1'b0, 4'b0000, 1'b0)) begin
            miscompares++;
            $display("FAIL illegal_idle got %h expected %h", obs(), pack(1'b0, m_dst, m_src, 1'b0, 4'b0000, 1'b0));
        end
        m_ptr = 3;
    endtask

    task automatic test_zero_reg();
        set_slot(0, 3'd0, 4'd6);
        wr_reg = 5'd0;
        req    = 4'b0001;
        for (int c = 1; c <= SETTLE + 1; c++) begin
            tick();
            vectors++;
            if (obs() !== pack(1'b1, 3'd0, 4'd6, 1'b0, 4'b0000, 1'b0)) begin
                miscompares++;
                $display("FAIL zero_reg_wr cyc%0d got %h expected %h", c, obs(), pack(1'b1, 3'd0, 4'd6, 1'b0, 4'b0000, 1'b0));
            end
        end
        tick();
        vectors++;
        if (obs() !== pack(1'b1, 3'd0, 4'd6, 1'b0, 4'b0001, 1'b0)) begin
            miscompares++;
            $display("FAIL zero_reg_ack got %h expected %h", obs(), pack(1'b1, 3'd0, 4'd6, 1'b0, 4'b0001, 1'b0));
        end
        req = '0;
        tick();
        m_ptr = 0;
        m_dst = 3'd0;
        m_src = 4'd6;
    endtask

    task automatic test_reset_mid();
        set_slot(2, 3'd3, 4'd7);
        wr_reg = 5'd9;
        req    = 4'b0100;
        tick();
        vectors++;
        if (obs() !== pack(1'b1, 3'd3, 4'd7, 1'b0, 4'b0000, 1'b0)) begin
            miscompares++;
            $display("FAIL rstmid_setup got %h expected %h", obs(), pack(1'b1, 3'd3, 4'd7, 1'b0, 4'b0000, 1'b0));
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (obs() !== 14'h0) begin
            miscompares++;
            $display("FAIL rstmid_forced got %h expected %h", obs(), 14'h0);
        end
        reset = 1'b0;
        req   = '0;
        model_reset();
        for (int c = 0; c < SETTLE + 3; c++) begin
            tick();
            vectors++;
            if (obs() !== 14'h0) begin
                miscompares++;
                $display("FAIL rstmid_aborted cyc%0d got %h expected %h", c, obs(), 14'h0);
            end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pending;
        logic [NREQ-1:0] exp_ack;
        logic [NREQ-1:0] no_ack;
        logic [2:0]      d;
        logic [3:0]      s;
        logic            exp_wr;
        int              w;
        pending = '0;
        no_ack  = '0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    set_slot(i, 3'($urandom_range(0, 5)), 4'($urandom));
                end
            end
            if (pending == '0) begin
                pending[0] = 1'b1;
                set_slot(0, 3'($urandom_range(0, 5)), 4'($urandom));
            end
            wr_reg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            req    = pending;
            w = model_winner(pending);
            d = req_dst[3*w +: 3];
            s = req_src[4*w +: 4];
            exp_ack = '0;
            exp_ack[w] = 1'b1;
            if (d > 3'd4) begin
                tick();
                vectors++;
                if (obs() !== pack(1'b1, m_dst, m_src, 1'b0, exp_ack, 1'b1)) begin
                    miscompares++;
                    $display("FAIL rand_drop txn%0d got %h expected %h", n, obs(), pack(1'b1, m_dst, m_src, 1'b0, exp_ack, 1'b1));
                end
            end else begin
                for (int c = 1; c <= SETTLE + 2; c++) begin
                    tick();
                    exp_wr = (c == SETTLE + 1) && (wr_reg != 5'd0);
                    vectors++;
                    if (obs() !== pack(1'b1, d, s, exp_wr, (c == SETTLE + 2) ? exp_ack : no_ack, 1'b0)) begin
                        miscompares++;
                        $display("FAIL rand_txn txn%0d cyc%0d got %h expected %h", n, c, obs(),
                                 pack(1'b1, d, s, exp_wr, (c == SETTLE + 2) ? exp_ack : no_ack, 1'b0));
                    end
                end
                m_dst = d;
                m_src = s;
            end
            m_ptr = w;
            pending[w] = 1'b0;
            req = pending;
            tick();
            vectors++;
            if (obs() !== pack(1'b0, m_dst, m_src, 1'b0, no_ack, 1'b0)) begin
                miscompares++;
                $display("FAIL rand_idle txn%0d got %h expected %h", n, obs(), pack(1'b0, m_dst, m_src, 1'b0, no_ack, 1'b0));
            end
        end
        req = '0;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req         = '0;
        req_dst     = '0;
        req_src     = '0;
        wr_reg      = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_write();
        test_arbitration();
        test_illegal_dst();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
